// File: rtl/inverter_loopback_tester.sv
// Stimulus/measurement controller for the analog inverter macro: toggles stim_out,
// times each synchronized response on resp_in and tallies timeouts per run.
module inverter_loopback_tester #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic [7:0] num_edges,
    output logic       stim_out,
    input  logic       resp_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] last_latency,
    output logic [7:0] max_latency
);

    localparam int unsigned      CNT_W       = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TOGGLE = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               stim_q, stim_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   max_q, max_d;
    logic [CNT_W-1:0]   edges_left_q, edges_left_d;
    logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0]   lat_inc;
    logic               edge_end;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   resp_sync;

    // Synchronizer idles at 1: the inverter output expected while IN=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], resp_in};
        end
    end

    assign resp_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d      = state_q;
        stim_d       = stim_q;
        pass_d       = pass_q;
        err_d        = err_q;
        last_d       = last_q;
        max_d        = max_q;
        edges_left_d = edges_left_q;
        lat_cnt_d    = lat_cnt_q;
        edge_end     = 1'b0;
        lat_inc      = lat_cnt_q + CNT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (start && ena) begin
                    edges_left_d = num_edges;
                    err_d        = '0;
                    last_d       = '0;
                    max_d        = '0;
                    pass_d       = 1'b0;
                    state_d      = (num_edges == '0) ? S_DONE : S_TOGGLE;
                end
            end
            S_TOGGLE: begin
                if (!ena) begin
                    pass_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    stim_d    = ~stim_q;
                    lat_cnt_d = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!ena) begin
                    pass_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    lat_cnt_d = lat_inc;
                    // A match in the timeout cycle still counts as a match.
                    if (resp_sync == ~stim_q) begin
                        last_d   = lat_inc;
                        if (lat_inc > max_q) begin
                            max_d = lat_inc;
                        end
                        edge_end = 1'b1;
                    end else if (lat_inc == TIMEOUT_VAL) begin
                        if (err_q != CNT_MAX) begin
                            err_d = err_q + CNT_W'(1);
                        end
                        last_d   = '0;
                        edge_end = 1'b1;
                    end
                    if (edge_end) begin
                        edges_left_d = edges_left_q - CNT_W'(1);
                        state_d      = (edges_left_q == CNT_W'(1)) ? S_DONE : S_TOGGLE;
                    end
                end
            end
            S_DONE: begin
                pass_d  = ena && (err_q == '0);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered flags track the state being entered.
        busy_d = (state_d == S_TOGGLE) || (state_d == S_WAIT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            stim_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            last_q       <= '0;
            max_q        <= '0;
            edges_left_q <= '0;
            lat_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            stim_q       <= stim_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            last_q       <= last_d;
            max_q        <= max_d;
            edges_left_q <= edges_left_d;
            lat_cnt_q    <= lat_cnt_d;
        end
    end

    assign stim_out     = stim_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_count    = err_q;
    assign last_latency = last_q;
    assign max_latency  = max_q;

endmodule

// File: tb/tb_inverter_loopback_tester.sv
// Self-checking bench for inverter_loopback_tester: directed plan steps, then random
// runs through ideal/delayed/stuck loopback models checked against an edge-level model.
module tb_inverter_loopback_tester;

    localparam int SYNC = 2;
    localparam int TMO  = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_edges = 8'd0;
    logic       stim_out;
    logic       resp_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] last_latency;
    logic [7:0] max_latency;

    // Loopback modes: 0 ideal, 1 delayed by dly clocks, 2 stuck 0, 3 stuck 1.
    int          mode = 0;
    int          dly = 1;
    logic [63:0] dly_q = '1;

    int checks = 0;
    int failures = 0;
    int toggle_cnt = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    logic stim_prev = 1'b0;

    inverter_loopback_tester #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .num_edges(num_edges),
        .stim_out(stim_out), .resp_in(resp_in), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .last_latency(last_latency), .max_latency(max_latency)
    );

    always #5 clk = ~clk;

    always @(posedge clk) dly_q <= {dly_q[62:0], ~stim_out};

    always_comb begin
        case (mode)
            1:       resp_in = dly_q[dly-1];
            2:       resp_in = 1'b0;
            3:       resp_in = 1'b1;
            default: resp_in = ~stim_out;
        endcase
    end

    // Event monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (stim_out !== stim_prev) toggle_cnt <= toggle_cnt + 1;
        stim_prev <= stim_out;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag, input int e_err, input int e_last,
                                 input int e_max, input logic e_pass, input logic e_stim);
        check({tag, "_err"},  32'(err_count),    32'(e_err));
        check({tag, "_last"}, 32'(last_latency), 32'(e_last));
        check({tag, "_max"},  32'(max_latency),  32'(e_max));
        check({tag, "_pass"}, 32'(pass),         32'(e_pass));
        check({tag, "_stim"}, 32'(stim_out),     32'(e_stim));
        check({tag, "_busy"}, 32'(busy),         32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_stim"}, 32'(stim_out),     32'd0);
        check({tag, "_busy"}, 32'(busy),         32'd0);
        check({tag, "_done"}, 32'(done),         32'd0);
        check({tag, "_pass"}, 32'(pass),         32'd0);
        check({tag, "_err"},  32'(err_count),    32'd0);
        check({tag, "_last"}, 32'(last_latency), 32'd0);
        check({tag, "_max"},  32'(max_latency),  32'd0);
    endtask

    // Start a run and wait (bounded) for its done pulse, then settle.
    task automatic run_edges(input logic [7:0] n, input int budget, input string tag);
        int d0;
        int c;
        d0 = done_cnt;
        start = 1'b1;
        num_edges = n;
        tick();
        start = 1'b0;
        c = 0;
        while (done_cnt == d0 && c < budget) begin
            tick();
            c++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
        tick();
        tick();
    endtask

    // Edge-level model: each edge either responds after a known latency or times out.
    task automatic model(input int md, input int d, input int n, input logic s0,
                         output int e_err, output int e_last, output int e_max,
                         output logic e_pass, output logic e_stim);
        logic s;
        int   lat;
        bit   ok;
        e_err = 0;
        e_last = 0;
        e_max = 0;
        s = s0;
        for (int i = 0; i < n; i++) begin
            if (md >= 2) begin
                ok  = ((md == 3) == (s == 1'b1));
                lat = 1;
            end else begin
                lat = ((md == 1) ? d : 0) + SYNC + 1;
                ok  = (lat <= TMO);
            end
            if (ok) begin
                e_last = lat;
                if (lat > e_max) e_max = lat;
            end else begin
                e_err  = (e_err < 255) ? e_err + 1 : 255;
                e_last = 0;
            end
            s = ~s;
        end
        e_pass = (e_err == 0);
        e_stim = s;
    endtask

    initial begin
        int   d0, t0, b0, c, tog, n, md, d;
        int   e_err, e_last, e_max;
        logic e_pass, e_stim_n, prev;
        logic exp_stim;

        exp_stim = 1'b0;

        // Reset state
        repeat (3) tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        ena = 1'b1;
        repeat (3) tick();

        // 1: ideal loopback, 4 edges
        mode = 0;
        d0 = done_cnt; t0 = toggle_cnt;
        run_edges(8'd4, 100, "t1");
        check_results("t1", 0, 3, 3, 1'b1, 1'b0);
        check("t1_toggles", 32'(toggle_cnt - t0), 32'd4);
        check("t1_done_once", 32'(done_cnt - d0), 32'd1);

        // 2: response delayed 10 clocks
        mode = 1; dly = 10;
        repeat (15) tick();
        run_edges(8'd2, 100, "t2");
        check_results("t2", 0, 13, 13, 1'b1, 1'b0);

        // 3: response stuck at 1
        mode = 3;
        repeat (5) tick();
        run_edges(8'd3, 1000, "t3");
        check_results("t3", 2, 0, 1, 1'b0, 1'b1);
        exp_stim = 1'b1;

        // 4: zero edges
        mode = 0;
        repeat (5) tick();
        b0 = busy_cnt; t0 = toggle_cnt;
        start = 1'b1; num_edges = 8'd0;
        tick();
        start = 1'b0;
        check("t4_done_next", 32'(done), 32'd1);
        tick();
        check("t4_done_pulse", 32'(done), 32'd0);
        check_results("t4", 0, 0, 0, 1'b1, exp_stim);
        check("t4_busy_never", 32'(busy_cnt - b0), 32'd0);
        check("t4_no_toggle", 32'(toggle_cnt - t0), 32'd0);

        // 5a: ena dropped during WAIT of edge 2 of 5
        repeat (5) tick();
        d0 = done_cnt;
        start = 1'b1; num_edges = 8'd5;
        tick();
        start = 1'b0;
        tog = 0; c = 0; prev = stim_out;
        while (tog < 2 && c < 100) begin
            tick();
            c++;
            if (stim_out !== prev) tog++;
            prev = stim_out;
        end
        check("t5a_reach_edge2", 32'(tog), 32'd2);
        ena = 1'b0;
        tick();
        check("t5a_busy_fall", 32'(busy), 32'd0);
        repeat (5) tick();
        check("t5a_no_done", 32'(done_cnt - d0), 32'd0);
        check_results("t5a", 0, 3, 3, 1'b0, exp_stim);
        ena = 1'b1;
        repeat (3) tick();

        // 5b: asynchronous reset mid-WAIT
        start = 1'b1; num_edges = 8'd5;
        tick();
        start = 1'b0;
        tog = 0; c = 0; prev = stim_out;
        while (tog < 1 && c < 100) begin
            tick();
            c++;
            if (stim_out !== prev) tog++;
        end
        check("t5b_busy_before", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1 check_reset_vals("t5b");
        #2 rst_n = 1'b1;
        exp_stim = 1'b0;
        repeat (3) tick();

        // 6: extra start pulses during a 3-edge run are ignored
        d0 = done_cnt; t0 = toggle_cnt;
        start = 1'b1; num_edges = 8'd3;
        tick();
        start = 1'b0;
        c = 0;
        while (done_cnt == d0 && c < 200) begin
            start = (busy === 1'b1 && (c % 3) == 0);
            tick();
            c++;
        end
        start = 1'b0;
        repeat (10) tick();
        check("t6_toggles", 32'(toggle_cnt - t0), 32'd3);
        check("t6_done_once", 32'(done_cnt - d0), 32'd1);
        check_results("t6", 0, 3, 3, 1'b1, 1'b1);
        exp_stim = 1'b1;

        // Random runs against the edge-level model
        for (int r = 0; r < 8; r++) begin
            md = int'($urandom_range(0, 3));
            d  = int'($urandom_range(1, 40));
            n  = int'($urandom_range(0, 5));
            mode = md;
            dly = d;
            repeat (70) tick();
            t0 = toggle_cnt;
            run_edges(8'(n), n * 300 + 20, "rand");
            model(md, d, n, exp_stim, e_err, e_last, e_max, e_pass, e_stim_n);
            check_results("rand", e_err, e_last, e_max, e_pass, e_stim_n);
            check("rand_toggles", 32'(toggle_cnt - t0), 32'(n));
            exp_stim = e_stim_n;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
